seg7_scan_decoder: RTL and testbench

//  Reverse path of the BCD/letter 7-segment encoders: snoops a multiplexed

---
 rtl/seg7_scan_if.sv | 29 ++
 rtl/seg7_scan_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: display-bus snoop inputs, symbol stream output and error
// status of the 7-segment scan decoder, bundled as one interface.
// master = environment side (drives the display bus, ready and err_clr),
// slave  = decoder side.
interface seg7_scan_if #(
    parameter int NDIG  = 4,
    parameter int IDX_W = 2
);
    logic [6:0]       seg_n;
    logic [NDIG-1:0]  dig_en;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [1:0]       out_kind;
    logic [3:0]       out_val;
    logic             out_last;
    logic             err_clr;
    logic [2:0]       err;

    modport master (
        output seg_n, dig_en, out_ready, err_clr,
        input  out_valid, out_idx, out_kind, out_val, out_last, err
    );

    modport slave (
        input  seg_n, dig_en, out_ready, err_clr,
        output out_valid, out_idx, out_kind, out_val, out_last, err
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: snoops a multiplexed active-low 7-segment bus, debounces
// each digit slot, decodes the segment pattern back to a symbol and streams
// every complete scan frame out digit by digit over valid/ready.
// Optional build macro SEG7_CHANGE_ONLY_EN: a complete frame identical to the
// last transmitted one is dropped silently (first frame after reset is always
// sent). Without the macro every complete frame is transmitted.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no frame pending, out_valid low, collecting digit captures
// SEND  | snapshot frame being streamed, out_idx selects the symbol
module seg7_scan_decoder #(
    parameter int NDIG   = 4,
    parameter int IDX_W  = 2,
    parameter int SETTLE = 3
) (
    input logic        clk,
    input logic        rst,
    seg7_scan_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    localparam logic [7:0]       CNT_MAX  = 8'hFF;
    localparam logic [7:0]       CNT_FIRE = 8'(SETTLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    logic [6:0]            seg_r, seg_p;
    logic [NDIG-1:0]       dig_r, dig_p;
    logic [7:0]            cnt_q, cnt_d;
    logic                  same, fire;
    logic                  dig_zero, dig_onehot, cap;
    logic [1:0]            dec_kind;
    logic [3:0]            dec_val;
    logic                  dec_unknown;
    logic [NDIG-1:0]       seen_q, seen_d;
    logic [NDIG-1:0][5:0]  bank_q, bank_d, snap_q, snap_d;
    logic                  frame_done, frame_dup, frame_take, overrun;
    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [2:0]            err_q, err_set;

    // Register the bus once, keep the previous sample and the run counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r <= '0;
            dig_r <= '0;
            seg_p <= '0;
            dig_p <= '0;
            cnt_q <= '0;
        end else begin
            seg_r <= bus.seg_n;
            dig_r <= bus.dig_en;
            seg_p <= seg_r;
            dig_p <= dig_r;
            cnt_q <= cnt_d;
        end
    end

    // Stability counter; capture fires once per stable run as it hits SETTLE-1
    always_comb begin
        same       = (seg_r == seg_p) && (dig_r == dig_p);
        cnt_d      = '0;
        if (same) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
        end
        fire       = (cnt_d == CNT_FIRE);
        dig_zero   = (dig_r == '0);
        dig_onehot = !dig_zero && ((dig_r & (dig_r - NDIG'(1))) == '0);
        cap        = fire && dig_onehot;
    end

    // Segment pattern to symbol; digit 0 takes precedence over letter O on 0x40
    always_comb begin
        dec_kind    = 2'd3;
        dec_val     = 4'hF;
        dec_unknown = 1'b0;
        case (seg_r)
            7'h40: begin dec_kind = 2'd0; dec_val = 4'd0; end
            7'h79: begin dec_kind = 2'd0; dec_val = 4'd1; end
            7'h24: begin dec_kind = 2'd0; dec_val = 4'd2; end
            7'h30: begin dec_kind = 2'd0; dec_val = 4'd3; end
            7'h19: begin dec_kind = 2'd0; dec_val = 4'd4; end
            7'h12: begin dec_kind = 2'd0; dec_val = 4'd5; end
            7'h02: begin dec_kind = 2'd0; dec_val = 4'd6; end
            7'h78: begin dec_kind = 2'd0; dec_val = 4'd7; end
            7'h00: begin dec_kind = 2'd0; dec_val = 4'd8; end
            7'h10: begin dec_kind = 2'd0; dec_val = 4'd9; end
            7'h06: begin dec_kind = 2'd1; dec_val = 4'd1; end
            7'h47: begin dec_kind = 2'd1; dec_val = 4'd2; end
            7'h46: begin dec_kind = 2'd1; dec_val = 4'd3; end
            7'h0C: begin dec_kind = 2'd1; dec_val = 4'd4; end
            7'h2F: begin dec_kind = 2'd1; dec_val = 4'd5; end
            7'h23: begin dec_kind = 2'd1; dec_val = 4'd6; end
            7'h3F: begin dec_kind = 2'd2; dec_val = 4'd0; end
            7'h7F: begin dec_kind = 2'd3; dec_val = 4'd0; end
            default: dec_unknown = 1'b1;
        endcase
    end

    // Write the captured symbol into its slot and detect a completed frame
    always_comb begin
        bank_d = bank_q;
        seen_d = seen_q;
        for (int i = 0; i < NDIG; i++) begin
            if (cap && dig_r[i]) begin
                bank_d[i] = {dec_kind, dec_val};
                seen_d[i] = 1'b1;
            end
        end
        frame_done = cap && (seen_d == '1);
        if (frame_done) begin
            seen_d = '0;
        end
    end

`ifdef SEG7_CHANGE_ONLY_EN
    logic sent_any_q;

    // Remember whether any frame has been transmitted since reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent_any_q <= 1'b0;
        end else if (frame_take) begin
            sent_any_q <= 1'b1;
        end
    end

    // The snapshot always holds the last transmitted frame
    always_comb begin
        frame_dup = sent_any_q && (bank_d == snap_q);
    end
`else
    // Every complete frame is a candidate for transmission
    always_comb begin
        frame_dup = 1'b0;
    end
`endif

    // Next state, stream index and frame accept/overrun decisions
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        frame_take = 1'b0;
        overrun    = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_done && !frame_dup) begin
                    state_d    = SEND;
                    idx_d      = '0;
                    frame_take = 1'b1;
                end
            end
            SEND: begin
                if (bus.out_ready && (idx_q == IDX_LAST)) begin
                    idx_d = '0;
                    if (frame_done && !frame_dup) begin
                        frame_take = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (bus.out_ready) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if (frame_done && !frame_dup) begin
                        overrun = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
        snap_d  = frame_take ? bank_d : snap_q;
        err_set = {overrun, cap && dec_unknown, fire && !dig_zero && !dig_onehot};
    end

    // State, index, slot bank, seen mask and frame snapshot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            seen_q  <= '0;
            bank_q  <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seen_q  <= seen_d;
            bank_q  <= bank_d;
            snap_q  <= snap_d;
        end
    end

    // Sticky error flags; a new set wins over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= (err_q & ~{3{bus.err_clr}}) | err_set;
        end
    end

    assign bus.out_valid = (state_q == SEND);
    assign bus.out_idx   = idx_q;
    assign bus.out_kind  = snap_q[idx_q][5:4];
    assign bus.out_val   = snap_q[idx_q][3:0];
    assign bus.out_last  = (state_q == SEND) && (idx_q == IDX_LAST);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed scenarios plus a randomized phase for the
// 7-segment scan decoder. A behavioural model tracks sample run lengths,
// slot contents and a queue of symbols still owed to the consumer; a compare
// process checks every output against it on each falling edge.
module tb_seg7_scan_decoder;
    localparam int NDIG   = 4;
    localparam int IDX_W  = 2;
    localparam int SETTLE = 3;

    typedef struct packed {
        logic [1:0] idx;
        logic [1:0] kind;
        logic [3:0] val;
        logic       last;
    } sym_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_if #(.NDIG(NDIG), .IDX_W(IDX_W)) bus ();

    seg7_scan_decoder #(.NDIG(NDIG), .IDX_W(IDX_W), .SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Symbol table straight from the decode rules
    function automatic void ref_decode(input logic [6:0] s, output logic [1:0] k,
                                       output logic [3:0] v, output bit unk);
        unk = 1'b0;
        case (s)
            7'h40: begin k = 0; v = 0; end
            7'h79: begin k = 0; v = 1; end
            7'h24: begin k = 0; v = 2; end
            7'h30: begin k = 0; v = 3; end
            7'h19: begin k = 0; v = 4; end
            7'h12: begin k = 0; v = 5; end
            7'h02: begin k = 0; v = 6; end
            7'h78: begin k = 0; v = 7; end
            7'h00: begin k = 0; v = 8; end
            7'h10: begin k = 0; v = 9; end
            7'h06: begin k = 1; v = 1; end
            7'h47: begin k = 1; v = 2; end
            7'h46: begin k = 1; v = 3; end
            7'h0C: begin k = 1; v = 4; end
            7'h2F: begin k = 1; v = 5; end
            7'h23: begin k = 1; v = 6; end
            7'h3F: begin k = 2; v = 0; end
            7'h7F: begin k = 3; v = 0; end
            default: begin k = 3; v = 4'hF; unk = 1'b1; end
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    sym_t       q[$];
    sym_t       tx_log[$];
    logic [5:0] m_bank [NDIG];
    logic [5:0] m_last_tx [NDIG];
    bit         m_seen [NDIG];
    bit         m_sent_any;
    logic [2:0] m_err;
    logic [6:0] prev_seg, pend_seg;
    logic [3:0] prev_dig, pend_dig;
    int         run;
    bit         pend;
    logic [2:0] m_set;
    logic [1:0] m_k;
    logic [3:0] m_v;
    bit         m_unk, m_all, m_dup;
    int         m_slot;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_err = '0;
            m_sent_any = 1'b0;
            for (int i = 0; i < NDIG; i++) begin
                m_bank[i] = '0; m_last_tx[i] = '0; m_seen[i] = 1'b0;
            end
            prev_seg = '0; prev_dig = '0; run = 2; pend = 1'b0;
        end else begin
            m_set = '0;
            if (q.size() > 0 && bus.out_ready) begin
                tx_log.push_back(q[0]);
                void'(q.pop_front());
            end
            if (pend && pend_dig != 0) begin
                if ($countones(pend_dig) != 1) begin
                    m_set[0] = 1'b1;
                end else begin
                    for (int i = 0; i < NDIG; i++) if (pend_dig[i]) m_slot = i;
                    ref_decode(pend_seg, m_k, m_v, m_unk);
                    if (m_unk) m_set[1] = 1'b1;
                    m_bank[m_slot] = {m_k, m_v};
                    m_seen[m_slot] = 1'b1;
                    m_all = 1'b1;
                    for (int i = 0; i < NDIG; i++) if (!m_seen[i]) m_all = 1'b0;
                    if (m_all) begin
                        for (int i = 0; i < NDIG; i++) m_seen[i] = 1'b0;
                        m_dup = 1'b0;
`ifdef SEG7_CHANGE_ONLY_EN
                        m_dup = m_sent_any;
                        for (int i = 0; i < NDIG; i++) if (m_bank[i] != m_last_tx[i]) m_dup = 1'b0;
`endif
                        if (!m_dup) begin
                            if (q.size() == 0) begin
                                for (int i = 0; i < NDIG; i++) begin
                                    q.push_back('{idx: 2'(i), kind: m_bank[i][5:4],
                                                  val: m_bank[i][3:0], last: (i == NDIG - 1)});
                                    m_last_tx[i] = m_bank[i];
                                end
                                m_sent_any = 1'b1;
                            end else begin
                                m_set[2] = 1'b1;
                            end
                        end
                    end
                end
            end
            m_err = (m_err & ~{3{bus.err_clr}}) | m_set;
            if (bus.seg_n == prev_seg && bus.dig_en == prev_dig) begin
                if (run < 1000) run++;
            end else begin
                run = 1;
            end
            prev_seg = bus.seg_n;
            prev_dig = bus.dig_en;
            pend     = (run == SETTLE);
            pend_seg = bus.seg_n;
            pend_dig = bus.dig_en;
        end
    end

    // Compare DUT outputs with the model every cycle out of reset
    always @(negedge clk) begin
        if (!rst) begin
            check("valid", bus.out_valid, q.size() != 0);
            if (q.size() != 0) begin
                check("idx",  bus.out_idx,  q[0].idx);
                check("kind", bus.out_kind, q[0].kind);
                check("val",  bus.out_val,  q[0].val);
                check("last", bus.out_last, q[0].last);
            end else begin
                check("last_idle", bus.out_last, 1'b0);
            end
            check("err", bus.err, m_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
        bus.seg_n  = s;
        bus.dig_en = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3, input int n);
        hold(s0, 4'b0001, n);
        hold(s1, 4'b0010, n);
        hold(s2, 4'b0100, n);
        hold(s3, 4'b1000, n);
    endtask

    task automatic check_log(input string name, input int base,
                             input logic [1:0] k0, input logic [3:0] v0,
                             input logic [1:0] k1, input logic [3:0] v1,
                             input logic [1:0] k2, input logic [3:0] v2,
                             input logic [1:0] k3, input logic [3:0] v3);
        logic [5:0] exp [4];
        exp[0] = {k0, v0}; exp[1] = {k1, v1}; exp[2] = {k2, v2}; exp[3] = {k3, v3};
        check({name, "_len"}, (tx_log.size() >= base + 4), 1);
        if (tx_log.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                check({name, "_sym"},  {tx_log[base+i].kind, tx_log[base+i].val}, exp[i]);
                check({name, "_idx"},  tx_log[base+i].idx, i);
                check({name, "_last"}, tx_log[base+i].last, (i == 3));
            end
        end
    endtask

    logic [6:0] pats [17] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h06, 7'h47, 7'h46, 7'h0C, 7'h2F, 7'h23, 7'h3F};

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        logic [6:0] rs;
        logic [3:0] rd;
        int n;

        bus.seg_n = 7'h7F; bus.dig_en = '0; bus.out_ready = 1'b1; bus.err_clr = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.out_valid, 0);
        check("rst_idx",   bus.out_idx, 0);
        check("rst_kind",  bus.out_kind, 0);
        check("rst_val",   bus.out_val, 0);
        check("rst_last",  bus.out_last, 0);
        check("rst_err",   bus.err, 0);
        rst = 1'b0;
        hold(7'h7F, 4'b0000, 3);

        // 1: plain scan, ready high
        tx_log.delete();
        scan(7'h79, 7'h24, 7'h30, 7'h19, 5);
        hold(7'h7F, 4'b0000, 12);
        check("t1_count", tx_log.size(), 4);
        check_log("t1", 0, 0, 1, 0, 2, 0, 3, 0, 4);
        check("t1_err", bus.err, 3'b000);

        // 2: each digit held one sample short of SETTLE
        tx_log.delete();
        for (int r = 0; r < 3; r++) scan(7'h79, 7'h24, 7'h30, 7'h19, SETTLE - 1);
        hold(7'h7F, 4'b0000, 12);
        check("t2_count", tx_log.size(), 0);
        check("t2_valid", bus.out_valid, 0);

        // 3: stalled consumer, second frame overruns
        tx_log.delete();
        bus.out_ready = 1'b0;
        scan(7'h0C, 7'h2F, 7'h40, 7'h7F, 5);
        hold(7'h7F, 4'b0000, 10);
        check("t3_hold_valid", bus.out_valid, 1);
        check("t3_hold_idx",   bus.out_idx, 0);
        check("t3_hold_sym",   {bus.out_kind, bus.out_val}, {2'd1, 4'd4});
        scan(7'h79, 7'h24, 7'h30, 7'h19, 5);
        hold(7'h7F, 4'b0000, 3);
        check("t3_overrun", bus.err, 3'b100);
        bus.out_ready = 1'b1;
        hold(7'h7F, 4'b0000, 10);
        check("t3_count", tx_log.size(), 4);
        check_log("t3", 0, 1, 4, 1, 5, 0, 0, 3, 0);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check("t3_clr", bus.err, 3'b000);

        // 4: multi-hot enable and unknown pattern; clear vs set precedence
        hold(7'h79, 4'b0011, 5);
        hold(7'h55, 4'b0001, 5);
        hold(7'h7F, 4'b0000, 2);
        check("t4_err", bus.err, 3'b011);
        check("t4_model_err", m_err, 3'b011);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        hold(7'h7F, 4'b0000, 2);
        check("t4_clr", bus.err, 3'b000);
        hold(7'h55, 4'b0010, 3);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        hold(7'h55, 4'b0010, 1);
        check("t4_set_wins", bus.err, 3'b010);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // 5: asynchronous reset while streaming idx 1
        hold(7'h79, 4'b0001, 5);
        hold(7'h24, 4'b0010, 5);
        hold(7'h30, 4'b0100, 5);
        bus.seg_n = 7'h19; bus.dig_en = 4'b1000;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_idx == 2'd1) found = 1'b1;
        end
        check("t5_reach_idx1", found, 1);
        #2 rst = 1'b1;
        #1 check("t5_async_valid", bus.out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        tx_log.delete();
        hold(7'h7F, 4'b0000, 3);
        scan(7'h79, 7'h24, 7'h30, 7'h19, 5);
        hold(7'h7F, 4'b0000, 12);
        check("t5_count", tx_log.size(), 4);
        check_log("t5", 0, 0, 1, 0, 2, 0, 3, 0, 4);

        // 6: repeated frame, then one digit changed
        tx_log.delete();
        scan(7'h12, 7'h79, 7'h24, 7'h30, 5);
        hold(7'h7F, 4'b0000, 8);
        scan(7'h12, 7'h79, 7'h24, 7'h30, 5);
        hold(7'h7F, 4'b0000, 8);
        scan(7'h02, 7'h79, 7'h24, 7'h30, 5);
        hold(7'h7F, 4'b0000, 10);
`ifdef SEG7_CHANGE_ONLY_EN
        check("t6_count", tx_log.size(), 8);
        check_log("t6a", 0, 0, 5, 0, 1, 0, 2, 0, 3);
        check_log("t6b", 4, 0, 6, 0, 1, 0, 2, 0, 3);
`else
        check("t6_count", tx_log.size(), 12);
        check_log("t6a", 0, 0, 5, 0, 1, 0, 2, 0, 3);
        check_log("t6b", 4, 0, 5, 0, 1, 0, 2, 0, 3);
        check_log("t6c", 8, 0, 6, 0, 1, 0, 2, 0, 3);
`endif
        check("t6_err", bus.err, 3'b000);

        // 7: randomized bus activity, random back-pressure and clears
        for (int seg_i = 0; seg_i < 400; seg_i++) begin
            rs = ($urandom_range(0, 9) < 8) ? pats[$urandom_range(0, 16)] : 7'($urandom);
            n  = $urandom_range(0, 99);
            if (n < 85)      rd = 4'(1 << $urandom_range(0, 3));
            else if (n < 92) rd = 4'b0000;
            else             rd = 4'($urandom);
            bus.seg_n  = rs;
            bus.dig_en = rd;
            repeat ($urandom_range(1, 6)) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                bus.err_clr   = ($urandom_range(0, 15) == 0);
                @(negedge clk);
            end
        end
        bus.err_clr   = 1'b0;
        bus.out_ready = 1'b1;
        hold(7'h7F, 4'b0000, 20);
        check("t7_drained", bus.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
